// File: rtl/cnt_share_arb_pkg.sv
// rtl/cnt_share_arb_pkg.sv - shared types, defaults and round-robin helper for cnt_share_arb
// Contents:
//   state_t   : arbiter FSM states (IDLE, RUN)
//   pick_t    : round-robin result {valid, idx}
//   rr_pick() : first set bit of req_vec searching ptr+1, ptr+2, ... modulo n
package cnt_share_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_CW    = 4;
  localparam int DEF_PRESC = 4;

  // rr_pick works on a fixed-width vector large enough for the biggest
  // supported NREQ; callers zero-extend their request vector.
  localparam int MAXREQ = 8;
  localparam int IDXW   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req_vec,
                                    input logic [IDXW-1:0]   ptr,
                                    input int                n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 1; k <= MAXREQ; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !p.valid && req_vec[j[IDXW-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = j[IDXW-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/cnt_share_rr.sv
// rtl/cnt_share_rr.sv - combinational round-robin picker for cnt_share_arb
// Ports:
//   eligible : requesters that may be granted this cycle
//   ptr      : index of the last winner; search starts at ptr+1
//   onehot   : one-hot winner (all zero when valid=0)
//   idx      : winner index
//   valid    : at least one eligible requester
module cnt_share_rr
  import cnt_share_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  pick_t pk;

  assign pk     = rr_pick(MAXREQ'(eligible), IDXW'(ptr), NREQ);
  assign valid  = pk.valid;
  assign idx    = pk.idx[IW-1:0];
  assign onehot = pk.valid ? (NREQ'(1) << pk.idx) : '0;

endmodule

// File: rtl/cnt_share_arb.sv
// rtl/cnt_share_arb.sv - round-robin arbiter and sequencer for one shared down-counter
// Optional feature macro: CNT_SHARE_ARB_PRESCALE_EN (adds parameter PRESC; the
// counter advances only once every PRESC clocks while owned).
// Ports:
//   clk  : system clock, rising edge
//   rstn : synchronous active-low reset
//   req  : per-requester request level, held until done or dropped to cancel
//   len  : packed lengths, requester i at [i*CW +: CW], sampled at grant
//   gnt  : one-hot registered grant
//   done : registered one-cycle completion pulse for the owner
//   busy : counter owned (state RUN)
//   cnt  : current counter value
module cnt_share_arb
  import cnt_share_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
`ifdef CNT_SHARE_ARB_PRESCALE_EN
  ,
  parameter int PRESC = DEF_PRESC
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [CW-1:0]    cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic [CW-1:0]   len_a [NREQ];
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            owner_req;
  logic            tick;

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_a[i] = len[i*CW +: CW];
  end

  // A requester in its done cycle is masked so it cannot be re-granted
  // while it is still dropping req.
  assign eligible = req & ~done_q;

  // gnt_q is one-hot while owned, so this is req of the owner.
  assign owner_req = |(req & gnt_q);

  cnt_share_rr #(.NREQ(NREQ)) u_rr (
    .eligible (eligible),
    .ptr      (ptr_q),
    .onehot   (pick_oh),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

`ifdef CNT_SHARE_ARB_PRESCALE_EN
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] psc_q, psc_d;

  assign tick = (psc_q == PW'(PRESC - 1));

  // Held at zero in IDLE so every grant starts a fresh prescale period.
  always_comb begin
    psc_d = psc_q;
    if (state_q == IDLE) begin
      psc_d = '0;
    end else if (owner_req) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_oh;
          cnt_d   = len_a[pick_idx];
          ptr_d   = pick_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!owner_req) begin
          // Cancel: release silently, counter value is left as is.
          gnt_d   = '0;
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q == '0) begin
            done_d  = gnt_q;
            gnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign cnt  = cnt_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_cnt_share_arb.sv
// tb/tb_cnt_share_arb.sv - scoreboard testbench for cnt_share_arb
module tb_cnt_share_arb;

  localparam int NREQ = 4;
  localparam int CW   = 4;
`ifdef CNT_SHARE_ARB_PRESCALE_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [NREQ-1:0] req  = '0;
  logic [NREQ*CW-1:0] len = '0;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            busy;
  logic [CW-1:0]   cnt;

`ifdef CNT_SHARE_ARB_PRESCALE_EN
  cnt_share_arb #(.NREQ(NREQ), .CW(CW), .PRESC(P)) dut (
`else
  cnt_share_arb #(.NREQ(NREQ), .CW(CW)) dut (
`endif
    .clk  (clk),
    .rstn (rstn),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       c;
    logic [3:0] g;
    logic [3:0] d;
    logic [3:0] n;
    logic       b;
  } ev_t;

  ev_t q[$];
  ev_t e;
  int  vectors = 0;
  int  errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int done_at(input int s, input int l);
    return s + 1 + (l + 1) * P;
  endfunction

  // Grant cycles of an owner whose request is sampled in cycle s, cut short
  // after ncyc cycles (cancel / reset cases).
  task automatic expect_part(input int s, input int idx, input int l, input int ncyc);
    for (int k = 0; k < ncyc; k++)
      q.push_back('{s + 1 + k, 4'(1 << idx), 4'b0, 4'(l - k / P), 1'b1});
  endtask

  task automatic expect_run(input int s, input int idx, input int l);
    expect_part(s, idx, l, (l + 1) * P);
    q.push_back('{done_at(s, l), 4'b0, 4'(1 << idx), 4'b0, 1'b0});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: structural invariants every cycle, scoreboard on any activity.
  always @(negedge clk) begin
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("gnt_done_overlap", 32'(gnt & done), 32'd0);
    chk("busy_vs_gnt", 32'(busy), 32'(gnt != '0));
    if (gnt != '0 || done != '0) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_activity at cycle %0d: gnt=%b done=%b cnt=%0d", cyc, gnt, done, cnt);
      end else begin
        e = q.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.c));
        chk("gnt", 32'(gnt), 32'(e.g));
        chk("done", 32'(done), 32'(e.d));
        chk("cnt", 32'(cnt), 32'(e.n));
        chk("busy", 32'(busy), 32'(e.b));
      end
    end
  end

  initial begin
    #400000;
    vectors++;
    errors++;
    $display("FAIL timeout: bench did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    int t;
    int s;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Single request, len0=3
    t = cyc;
    len = 16'h0003;
    req = 4'b0001;
    expect_run(t, 0, 3);
    wait_to(done_at(t, 3));
    req = 4'b0000;
    wait_to(cyc + 2);

    // Fairness after reset: 0,1,2,3,0 with len=1
    do_reset();
    len = 16'h1111;
    t = cyc;
    req = 4'b1111;
    for (int j = 0; j < 5; j++)
      expect_run(t + j * (2 * P + 1), j % 4, 1);
    wait_to(done_at(t + 4 * (2 * P + 1), 1));
    req = 4'b0000;
    wait_to(cyc + 2);

    // Zero length; req held through done cycle must not be re-granted
    len = 16'h0000;
    t = cyc;
    req = 4'b0100;
    expect_run(t, 2, 0);
    wait_to(done_at(t, 0) + 1);
    req = 4'b0000;
    wait_to(cyc + 2);

    // Cancel at cnt=2; req3 arrives during RUN and follows
    len = 16'h1050;
    t = cyc;
    req = 4'b0010;
    expect_part(t, 1, 5, 3 * P + 1);
    wait_to(t + 2);
    req = 4'b1010;
    wait_to(t + 1 + 3 * P);
    req = 4'b1000;
    s = t + 2 + 3 * P;
    expect_run(s, 3, 1);
    wait_to(done_at(s, 1));
    req = 4'b0000;
    wait_to(cyc + 2);

    // Reset mid-run at cnt=4, then pointer must restart at requester 0
    len = 16'h0006;
    t = cyc;
    req = 4'b0001;
    expect_part(t, 0, 6, 2 * P + 1);
    wait_to(t + 1 + 2 * P);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    len = 16'h0000;
    req = 4'b0011;
    t = cyc;
    expect_run(t, 0, 0);
    s = done_at(t, 0);
    expect_run(s, 1, 0);
    wait_to(s);
    req = 4'b0010;
    wait_to(done_at(s, 0));
    req = 4'b0000;
    wait_to(cyc + 3);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
